// File: rtl/ha_struct_pkg.sv
// Shared types and constants for the ha_struct lane-parallel half adder.
package ha_struct_pkg;

  localparam int unsigned WidthDefault = 1;
  localparam int unsigned MaxWidth     = 64;

  // One lane's registered result.
  typedef struct packed {
    logic carry;
    logic sum;
  } lane_res_t;

  // Behavioural reference for one lane: {carry, sum} is the 2-bit sum of a and b.
  function automatic lane_res_t lane_add(input logic a, input logic b);
    logic [1:0] total;
    lane_res_t  res;
    total     = {1'b0, a} + {1'b0, b};
    res.carry = total[1];
    res.sum   = total[0];
    return res;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Single-lane half adder built from gate primitives; purely combinational.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  xor u_xor (s, a, b);
  and u_and (c, a, b);

endmodule

// File: rtl/ha_struct.sv
// WIDTH independent half-adder lanes with a one-cycle registered result.
// Optional self-check: define HA_STRUCT_CHECK_EN to add the chk_err port and a
// behavioural reference model that cross-checks the gate-level cells.
module ha_struct
  import ha_struct_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
`ifdef HA_STRUCT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_width_check
    $error("ha_struct: WIDTH must be in 1..%0d", MaxWidth);
  end

  logic [WIDTH-1:0] cell_s;
  logic [WIDTH-1:0] cell_c;

  lane_res_t [WIDTH-1:0] res_q;
  logic                  out_valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (cell_s[i]),
      .c (cell_c[i])
    );
  end

  // Capture lane results on accepted inputs; reset dominates in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          res_q[i].sum   <= cell_s[i];
          res_q[i].carry <= cell_c[i];
        end
      end
    end
  end

  // Unpack registered lane structs onto the flat output buses.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]   = res_q[i].sum;
      carry[i] = res_q[i].carry;
    end
  end

  assign out_valid = out_valid_q;

`ifdef HA_STRUCT_CHECK_EN
  logic [WIDTH-1:0] ref_s;
  logic [WIDTH-1:0] ref_c;
  logic             mismatch;
  logic             chk_err_q;

  // Reference results per lane, compared against the gate cells.
  always_comb begin
    lane_res_t r;
    ref_s = '0;
    ref_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r        = lane_add(a[i], b[i]);
      ref_s[i] = r.sum;
      ref_c[i] = r.carry;
    end
    // Only accepted inputs count, so garbage on idle cycles cannot raise an error.
    mismatch = in_valid & (|((ref_s ^ cell_s) | (ref_c ^ cell_c)));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if (mismatch) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_ha_struct.sv
// Self-checking bench for ha_struct: an 8-lane and a 1-lane instance share stimulus
// (the 1-lane instance sees lane 0). Expected results are queued by the driver and
// consumed by a monitor on the falling edge.
module tb_ha_struct;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] a        = '0;
  logic [7:0] b        = '0;
  logic       in_valid = 1'b0;

  logic [7:0] sum8;
  logic [7:0] carry8;
  logic       ov8;
  logic [0:0] sum1;
  logic [0:0] carry1;
  logic       ov1;
`ifdef HA_STRUCT_CHECK_EN
  logic       chk8;
  logic       chk1;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned cyc         = 0;
  logic        rst_at_edge = 1'b0;
  logic        mon_en      = 1'b0;
  logic [7:0]  held_s      = '0;
  logic [7:0]  held_c      = '0;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  s;
    logic [7:0]  c;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ha_struct #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum8),
    .carry     (carry8),
    .out_valid (ov8)
`ifdef HA_STRUCT_CHECK_EN
    ,
    .chk_err   (chk8)
`endif
  );

  ha_struct #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .in_valid  (in_valid),
    .sum       (sum1),
    .carry     (carry1),
    .out_valid (ov1)
`ifdef HA_STRUCT_CHECK_EN
    ,
    .chk_err   (chk1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: each lane adds two one-bit numbers; low bit is sum, high bit is carry.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv,
                                output logic [7:0] s, output logic [7:0] c);
    int t;
    for (int i = 0; i < 8; i++) begin
      t    = int'(av[i]) + int'(bv[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
  endfunction

  // Drive one cycle of stimulus and queue the result it should produce.
  task automatic step(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    if (!r && v) begin
      e.cyc = cyc + 1;
      model(av, bv, e.s, e.c);
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor: pop the result due this cycle, otherwise expect held (or reset) values.
  always @(negedge clk) begin : monitor
    logic exp_v;
    exp_t e;
    if (mon_en && cyc != 0) begin
      exp_v = (q.size() != 0) && (q[0].cyc == cyc);
      if (exp_v) begin
        e      = q.pop_front();
        held_s = e.s;
        held_c = e.c;
      end else if (rst_at_edge) begin
        held_s = '0;
        held_c = '0;
      end
      check("out_valid8", 64'(ov8), 64'(exp_v));
      check("sum8", 64'(sum8), 64'(held_s));
      check("carry8", 64'(carry8), 64'(held_c));
      check("out_valid1", 64'(ov1), 64'(exp_v));
      check("sum1", 64'(sum1), 64'(held_s[0]));
      check("carry1", 64'(carry1), 64'(held_c[0]));
`ifdef HA_STRUCT_CHECK_EN
      check("chk_err8", 64'(chk8), 64'd0);
      check("chk_err1", 64'(chk1), 64'd0);
`endif
    end
  end

  initial begin
    mon_en = 1'b1;
    // Reset for two cycles with a valid (1,1) input that must be dropped.
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    // Truth table on lane 0, back to back.
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    // Mixed lanes.
    step(1'b0, 1'b1, 8'hF0, 8'h3C);
    // (1,1) then three idle cycles: carry must hold.
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00);
    // Reset wins over a simultaneous valid input.
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Random traffic; idle cycles carry junk on a/b.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0),
           8'($urandom_range(255)), 8'($urandom_range(255)));
    end
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_drained", 64'(q.size()), 64'd0);

`ifdef HA_STRUCT_CHECK_EN
    // Fault on lane 0 of the 8-lane instance: (0,0) should give sum 0, force it to 1.
    step(1'b0, 1'b1, 8'h00, 8'h00);
    force dut8.g_lane[0].u_cell.s = 1'b1;
    @(posedge clk);
    #1;
    release dut8.g_lane[0].u_cell.s;
    check("chk_err8_set", 64'(chk8), 64'd1);
    check("chk_err1_clean", 64'(chk1), 64'd0);
    repeat (2) step(1'b0, 1'b1, 8'h5A, 8'hA5);
    @(posedge clk);
    #1;
    check("chk_err8_sticky", 64'(chk8), 64'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check("chk_err8_reset", 64'(chk8), 64'd0);
    q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
